preadd_mac: RTL and testbench

Parametrised pre-adder multiply-accumulate with valid tracking, selectable pre-add/pre-subtract, optional accumulation with saturation, and a sticky overflow flag. Successor to the fixed pre-add multiplier: four-stage pipelined datapath computing (a ± d) × b, summed into a guarded accumulator across a frame. Sits in DSP filter/correlator chains, one instance per tap or channel.

---
 rtl/preadd_mac_pkg.sv | 33 +++
 rtl/preadd_mac_acc.sv | 86 ++++++++
 rtl/preadd_mac.sv | 112 +++++++++++
 tb/tb_preadd_mac.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/preadd_mac_pkg.sv
// +--------------------------------------------------------------------------+
// | preadd_mac_pkg : shared types and width/saturation helpers for preadd_mac |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package preadd_mac_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } preadd_op_e;

  localparam int c_SAT_W = 128;

  function automatic int mac_width(input int aw, input int bw, input int gw, input int acc_en);
    return (acc_en != 0) ? (aw + 1 + bw + gw) : (aw + 1 + bw);
  endfunction

  // Bit patterns only; callers keep the low w bits.
  function automatic logic [c_SAT_W-1:0] sat_max(input int w);
    logic [c_SAT_W-1:0] one;
    one = c_SAT_W'(1);
    return (one << (w - 1)) - one;
  endfunction

  function automatic logic [c_SAT_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/preadd_mac_acc.sv
// +--------------------------------------------------------------------------+
// | preadd_mac_acc : output stage, frame accumulator with sticky overflow     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module preadd_mac_acc
  import preadd_mac_pkg::*;
#(
  parameter int MW     = 33,
  parameter int PW     = 41,
  parameter int ACC_EN = 1,
  parameter int SAT_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 i_valid,
  input  logic                 i_first,
  input  logic signed [MW-1:0] i_prod,
  output logic                 o_valid,
  output logic signed [PW-1:0] o_acc,
  output logic                 o_ovf
);

  logic                 r_valid;
  logic signed [PW-1:0] r_acc;
  logic                 r_ovf;
  logic signed [PW-1:0] w_next;
  logic                 w_ovf_next;

  generate
    if (ACC_EN != 0) begin : g_acc
      localparam logic [c_SAT_W-1:0] c_MAX_FULL = sat_max(PW);
      localparam logic [c_SAT_W-1:0] c_MIN_FULL = sat_min(PW);
      localparam logic signed [PW-1:0] c_MAX = c_MAX_FULL[PW-1:0];
      localparam logic signed [PW-1:0] c_MIN = c_MIN_FULL[PW-1:0];

      logic signed [PW:0] w_pext;
      logic signed [PW:0] w_sum;
      logic               w_ovf;

      always_comb begin
        w_pext = {{(PW + 1 - MW){i_prod[MW-1]}}, i_prod};
        w_sum  = {r_acc[PW-1], r_acc} + w_pext;
        // One guard bit suffices: disagreement of the top two bits is overflow.
        w_ovf  = w_sum[PW] ^ w_sum[PW-1];
        w_next     = w_sum[PW-1:0];
        w_ovf_next = r_ovf | w_ovf;
        if (w_ovf && (SAT_EN != 0)) begin
          w_next = w_sum[PW] ? c_MIN : c_MAX;
        end
        if (i_first) begin
          w_next     = w_pext[PW-1:0];
          w_ovf_next = 1'b0;
        end
      end
    end else begin : g_pass
      always_comb begin
        w_next     = i_prod;
        w_ovf_next = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (ce) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_acc <= w_next;
        r_ovf <= w_ovf_next;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_acc   = r_acc;
  assign o_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/preadd_mac.sv
// +--------------------------------------------------------------------------+
// | preadd_mac : pipelined (a +/- d) * b with optional frame accumulation     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module preadd_mac
  import preadd_mac_pkg::*;
#(
  parameter  int AW     = 16,
  parameter  int BW     = 16,
  parameter  int GW     = 8,
  parameter  int ACC_EN = 1,
  parameter  int SAT_EN = 1,
  localparam int MW     = AW + 1 + BW,
  localparam int PW     = mac_width(AW, BW, GW, ACC_EN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 first,
  input  logic                 sub,
  input  logic signed [AW-1:0] ain,
  input  logic signed [AW-1:0] din,
  input  logic signed [BW-1:0] bin,
  output logic                 out_valid,
  output logic signed [PW-1:0] pout,
  output logic                 ovf
);

  logic signed [AW-1:0] r_ain;
  logic signed [AW-1:0] r_din;
  logic signed [BW-1:0] r_bin1;
  preadd_op_e           r_op1;
  logic                 r_first1;
  logic                 r_v1;

  logic signed [AW:0]   r_pre;
  logic signed [BW-1:0] r_bin2;
  logic                 r_first2;
  logic                 r_v2;

  logic signed [MW-1:0] r_prod;
  logic                 r_first3;
  logic                 r_v3;

  logic signed [AW:0]   w_a_ext;
  logic signed [AW:0]   w_d_ext;
  logic signed [MW-1:0] w_pre_ext;
  logic signed [MW-1:0] w_b_ext;

  assign w_a_ext   = {r_ain[AW-1], r_ain};
  assign w_d_ext   = {r_din[AW-1], r_din};
  // Operands widened to MW so the low MW bits of the product are exact.
  assign w_pre_ext = {{BW{r_pre[AW]}}, r_pre};
  assign w_b_ext   = {{(AW + 1){r_bin2[BW-1]}}, r_bin2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ain    <= '0;
      r_din    <= '0;
      r_bin1   <= '0;
      r_op1    <= OP_ADD;
      r_first1 <= 1'b0;
      r_v1     <= 1'b0;
      r_pre    <= '0;
      r_bin2   <= '0;
      r_first2 <= 1'b0;
      r_v2     <= 1'b0;
      r_prod   <= '0;
      r_first3 <= 1'b0;
      r_v3     <= 1'b0;
    end else if (ce) begin
      r_ain    <= ain;
      r_din    <= din;
      r_bin1   <= bin;
      r_op1    <= (in_valid && sub) ? OP_SUB : OP_ADD;
      r_first1 <= in_valid & first;
      r_v1     <= in_valid;

      r_pre    <= (r_op1 == OP_SUB) ? (w_a_ext - w_d_ext) : (w_a_ext + w_d_ext);
      r_bin2   <= r_bin1;
      r_first2 <= r_first1;
      r_v2     <= r_v1;

      r_prod   <= w_pre_ext * w_b_ext;
      r_first3 <= r_first2;
      r_v3     <= r_v2;
    end
  end

  preadd_mac_acc #(
    .MW     (MW),
    .PW     (PW),
    .ACC_EN (ACC_EN),
    .SAT_EN (SAT_EN)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .i_valid (r_v3),
    .i_first (r_first3),
    .i_prod  (r_prod),
    .o_valid (out_valid),
    .o_acc   (pout),
    .o_ovf   (ovf)
  );

endmodule

`default_nettype wire

// File: tb/tb_preadd_mac.sv
// +--------------------------------------------------------------------------+
// | tb_preadd_mac : four configurations driven in parallel vs reference model |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_preadd_mac;

  logic               clk;
  logic               rst_n;
  logic               ce;
  logic               in_valid;
  logic               first;
  logic               sub;
  logic signed [15:0] ain;
  logic signed [15:0] din;
  logic signed [15:0] bin;

  logic               ov0, ov1, ov2, ov3;
  logic               of0, of1, of2, of3;
  logic signed [40:0] p0;
  logic signed [32:0] p1, p2, p3;

  // 0: accumulate+sat GW=8, 1: plain multiply, 2: GW=0 saturate, 3: GW=0 wrap
  preadd_mac #(.AW(16), .BW(16), .GW(8), .ACC_EN(1), .SAT_EN(1)) u_acc (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .ain(ain), .din(din), .bin(bin), .out_valid(ov0), .pout(p0), .ovf(of0));
  preadd_mac #(.AW(16), .BW(16), .GW(8), .ACC_EN(0), .SAT_EN(1)) u_mul (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .ain(ain), .din(din), .bin(bin), .out_valid(ov1), .pout(p1), .ovf(of1));
  preadd_mac #(.AW(16), .BW(16), .GW(0), .ACC_EN(1), .SAT_EN(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .ain(ain), .din(din), .bin(bin), .out_valid(ov2), .pout(p2), .ovf(of2));
  preadd_mac #(.AW(16), .BW(16), .GW(0), .ACC_EN(1), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .first(first), .sub(sub),
    .ain(ain), .din(din), .bin(bin), .out_valid(ov3), .pout(p3), .ovf(of3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     v;
    bit     f;
    bit     s;
    longint a;
    longint d;
    longint b;
  } samp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  samp_t  q[$];
  longint m_pout[4];
  bit     m_ovf[4];
  bit     m_valid;
  int     c_pw[4]  = '{41, 33, 33, 33};
  bit     c_acc[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit     c_sat[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint x, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = x & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  task automatic model_reset();
    samp_t bub;
    bub = '{v: 1'b0, f: 1'b0, s: 1'b0, a: 0, d: 0, b: 0};
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(bub);
    m_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_pout[i] = 0;
      m_ovf[i]  = 1'b0;
    end
  endtask

  // Result of a sample appears on the fourth enabled edge counting its own.
  task automatic model_edge(input samp_t s_in);
    samp_t  s;
    longint prod, sum, mx, mn;
    q.push_back(s_in);
    s = q.pop_front();
    m_valid = s.v;
    if (!s.v) return;
    prod = (s.a + (s.s ? -s.d : s.d)) * s.b;
    for (int i = 0; i < 4; i++) begin
      mx = (longint'(1) << (c_pw[i] - 1)) - 1;
      mn = -(longint'(1) << (c_pw[i] - 1));
      if (!c_acc[i]) begin
        m_pout[i] = prod;
        m_ovf[i]  = 1'b0;
      end else if (s.f) begin
        m_pout[i] = prod;
        m_ovf[i]  = 1'b0;
      end else begin
        sum = m_pout[i] + prod;
        if (sum > mx || sum < mn) begin
          m_ovf[i]  = 1'b1;
          m_pout[i] = c_sat[i] ? ((sum > mx) ? mx : mn) : wrapw(sum, c_pw[i]);
        end else begin
          m_pout[i] = sum;
        end
      end
    end
  endtask

  task automatic compare_all();
    longint act_p[4];
    bit     act_v[4];
    bit     act_o[4];
    act_p = '{longint'(p0), longint'(p1), longint'(p2), longint'(p3)};
    act_v = '{ov0, ov1, ov2, ov3};
    act_o = '{of0, of1, of2, of3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid%0d", i), longint'(act_v[i]), longint'(m_valid));
      check($sformatf("pout%0d", i), act_p[i], m_pout[i]);
      check($sformatf("ovf%0d", i), longint'(act_o[i]), longint'(m_ovf[i]));
    end
  endtask

  task automatic step(input bit v, input bit f, input bit s, input logic signed [15:0] a,
                      input logic signed [15:0] d, input logic signed [15:0] b, input bit c);
    samp_t smp;
    in_valid = v;
    first    = f;
    sub      = s;
    ain      = a;
    din      = d;
    bin      = b;
    ce       = c;
    smp = '{v: v, f: f, s: s, a: longint'(a), d: longint'(d), b: longint'(b)};
    @(posedge clk);
    if (c && rst_n) model_edge(smp);
    #1;
    compare_all();
  endtask

  task automatic bubble();
    step(1'b0, 1'b1, 1'b1, 16'sd0, 16'sd0, 16'sd0, 1'b1);
  endtask

  function automatic logic signed [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return -16'sd32768;
      1:       return 16'sd32767;
      2:       return 16'(signed'($urandom_range(0, 8)) - 4);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_run(input int n, input int ce_pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, 1'($urandom),
           pick(), pick(), pick(), $urandom_range(0, 99) < ce_pct);
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  longint exp_frame[5] = '{4, 10, 2, 2, 2};

  initial begin
    rst_n = 1'b0;
    ce = 1'b1; in_valid = 1'b0; first = 1'b0; sub = 1'b0;
    ain = '0; din = '0; bin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_pout0", longint'(p0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain multiply: latency and exact products.
    step(1'b1, 1'b1, 1'b0, 16'sd3, 16'sd4, 16'sd5, 1'b1);
    step(1'b1, 1'b1, 1'b1, -16'sd10, 16'sd10, -16'sd10, 1'b1);
    step(1'b1, 1'b1, 1'b0, -16'sd32768, -16'sd32768, -16'sd32768, 1'b1);
    check("lat_early", longint'(ov1), 0);
    bubble();
    check("mul35", longint'(p1), 35);
    check("lat_exact", longint'(ov1), 1);
    bubble();
    check("mul200", longint'(p1), 200);
    bubble();
    check("mul2p31", longint'(p1), 64'sd2147483648);
    bubble();
    check("bubble_hold", longint'(p1), 64'sd2147483648);

    // Accumulated frame followed by a back-to-back new frame.
    step(1'b1, 1'b1, 1'b0, 16'sd1, 16'sd1, 16'sd2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'sd2, 16'sd0, 16'sd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, -16'sd3, 16'sd1, 16'sd4, 1'b1);
    for (int j = 0; j < 5; j++) begin
      if (j == 0) step(1'b1, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd9, 1'b1);
      else if (j == 1) step(1'b1, 1'b1, 1'b0, 16'sd1, 16'sd1, 16'sd1, 1'b1);
      else bubble();
      check($sformatf("frame%0d", j), longint'(p0), exp_frame[j]);
    end

    // Saturation versus wrap with repeated largest positive product.
    for (int j = 0; j < 4; j++)
      step(1'b1, j == 0, 1'b0, -16'sd32768, -16'sd32768, -16'sd32768, 1'b1);
    repeat (3) bubble();
    check("sat_pin", longint'(p2), (longint'(1) << 32) - 1);
    check("sat_ovf", longint'(of2), 1);
    check("wrap_val", longint'(p3), 0);
    check("wrap_ovf", longint'(of3), 1);
    step(1'b1, 1'b1, 1'b0, 16'sd1, 16'sd0, 16'sd1, 1'b1);
    repeat (3) bubble();
    check("ovf_clear", longint'(of2), 0);

    // Clock-enable stalls interleaved with bubbles.
    step(1'b1, 1'b1, 1'b0, 16'sd5, 16'sd2, 16'sd3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 16'sd0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'sd7, 16'sd1, 16'sd2, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'sd100, 16'sd100, 16'sd100, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'sd1, 16'sd2, 16'sd3, 1'b1);
    repeat (4) bubble();
    rand_run(300, 80);

    // Reset with samples in flight mid-frame.
    step(1'b1, 1'b1, 1'b0, 16'sd9, 16'sd9, 16'sd9, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'sd8, 16'sd8, 16'sd8, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'sd7, 16'sd7, 16'sd7, 1'b1);
    hard_reset();
    check("rst_flush_v", longint'(ov0), 0);
    repeat (5) bubble();
    check("no_ghost", longint'(ov0), 0);

    // Valid with first=0 right after reset accumulates onto zero.
    step(1'b1, 1'b0, 1'b0, 16'sd2, 16'sd3, 16'sd4, 1'b1);
    repeat (3) bubble();
    check("acc_from_zero", longint'(p0), 20);
    rand_run(300, 90);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
